// File: rtl/plate_assembler_pkg.sv
// rtl/plate_assembler_pkg.sv - shared constants for the plate assembler and judge stage
//
// Purpose : state encoding, empty-slot marker and the default geometry shared by
//           plate_assembler, its interface and the upstream judge stage.
// Ports   : none (package).
package plate_assembler_pkg;

  // FSM encoding kept as plain constants so legacy tooling can decode the state bits.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_OUTPUT  = 2'd2;

  localparam int DEFAULT_NUM_CHARS = 7;
  localparam int CHAR_IDX_W        = 4;   // index width produced by the judge stage
  localparam int DEFAULT_TMO_W     = 24;

  localparam logic [CHAR_IDX_W-1:0] EMPTY_SLOT = 4'hF;

  typedef logic [CHAR_IDX_W-1:0] char_idx_t;

endpackage

// File: rtl/plate_assembler_if.sv
// rtl/plate_assembler_if.sv - finished-plate valid/ready bundle
//
// Purpose : carries one assembled plate from the assembler to the CPU-side register block.
// Signals : plate_valid  master->slave  plate word available
//           plate_ready  slave->master  consumer accepts the plate
//           plate_data   master->slave  NUM_CHARS*IDX_W, slot 0 in the low bits
//           plate_count  master->slave  characters actually captured
//           plate_error  master->slave  plate closed by stall timeout
interface plate_assembler_if #(
  parameter int NUM_CHARS = plate_assembler_pkg::DEFAULT_NUM_CHARS,
  parameter int IDX_W     = plate_assembler_pkg::CHAR_IDX_W
) ();

  logic                       plate_valid;
  logic                       plate_ready;
  logic [NUM_CHARS*IDX_W-1:0] plate_data;
  logic [3:0]                 plate_count;
  logic                       plate_error;

  modport master (
    output plate_valid,
    output plate_data,
    output plate_count,
    output plate_error,
    input  plate_ready
  );

  modport slave (
    input  plate_valid,
    input  plate_data,
    input  plate_count,
    input  plate_error,
    output plate_ready
  );

endinterface

// File: rtl/plate_stall_timer.sv
// rtl/plate_stall_timer.sv - saturating per-character stall timer
//
// Purpose : counts idle cycles between characters and flags expiry at the limit.
// Ports   : clk, rst_n  clock, async active-low reset
//           clear       restart counting from zero (wins over enable)
//           enable      count this cycle
//           limit       expiry limit in cycles, 0 disables expiry
//           expire      combinational pulse: this enabled cycle completes the limit
module plate_stall_timer #(
  parameter int TMO_W = plate_assembler_pkg::DEFAULT_TMO_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMO_W-1:0] limit,
  output logic             expire
);

  logic [TMO_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + TMO_W'(1);
    end
  end

  // count holds the idle cycles already elapsed, so the limit-th idle cycle is count==limit-1.
  assign expire = enable && !clear && (limit != '0) && (count == limit - TMO_W'(1));

endmodule

// File: rtl/plate_assembler.sv
// rtl/plate_assembler.sv - packs judged character indices into one plate word
//
// Purpose : captures one index per rising recognize_done, packs NUM_CHARS of them,
//           hands the plate over a valid/ready bundle and closes stalled plates on timeout.
// Ports   : clk, rst_n      clock, async active-low reset
//           frame_start     pulse, begins (or restarts) a plate
//           char_index      index from the judge, stable while recognize_done is high
//           recognize_done  level from the judge, rising edge = one new character
//           tmo_cycles      stall limit, 0 disables the timeout
//           all_done        to the judge: plate complete or aborted
//           busy            collecting characters
//           overrun         sticky, character edge seen outside collection
//           plate           finished-plate bundle (master side)
module plate_assembler
  import plate_assembler_pkg::*;
#(
  parameter int NUM_CHARS = DEFAULT_NUM_CHARS,
  parameter int IDX_W     = CHAR_IDX_W,
  parameter int TMO_W     = DEFAULT_TMO_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic [IDX_W-1:0] char_index,
  input  logic             recognize_done,
  input  logic [TMO_W-1:0] tmo_cycles,
  output logic             all_done,
  output logic             busy,
  output logic             overrun,
  plate_assembler_if.master plate
);

  localparam int                   DATA_W      = NUM_CHARS * IDX_W;
  localparam logic [DATA_W-1:0]    EMPTY_PLATE = {NUM_CHARS{IDX_W'(EMPTY_SLOT)}};
  localparam logic [3:0]           LAST_SLOT   = 4'(NUM_CHARS - 1);

  logic [1:0]        state_q;
  logic              rd_q;
  logic [DATA_W-1:0] data_q;
  logic [3:0]        count_q;
  logic              error_q;
  logic              overrun_q;

  logic char_evt;
  logic timer_clear;
  logic timer_en;
  logic expire;

  // A level already high on COLLECT entry is not an event until it drops and rises again.
  assign char_evt    = recognize_done & ~rd_q;
  assign timer_clear = frame_start | char_evt;
  assign timer_en    = (state_q == ST_COLLECT) & ~char_evt;

  plate_stall_timer #(.TMO_W(TMO_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_en),
    .limit  (tmo_cycles),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rd_q      <= 1'b0;
      data_q    <= EMPTY_PLATE;
      count_q   <= 4'd0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rd_q <= recognize_done;
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            state_q   <= ST_COLLECT;
            data_q    <= EMPTY_PLATE;
            count_q   <= 4'd0;
            error_q   <= 1'b0;
            overrun_q <= 1'b0;
          end else if (char_evt) begin
            overrun_q <= 1'b1;
          end
        end
        ST_COLLECT: begin
          // A restart beats a coincident character, which is dropped.
          if (frame_start) begin
            data_q    <= EMPTY_PLATE;
            count_q   <= 4'd0;
            error_q   <= 1'b0;
            overrun_q <= 1'b0;
          end else if (char_evt) begin
            for (int i = 0; i < NUM_CHARS; i++) begin
              if (count_q == 4'(i)) data_q[i*IDX_W +: IDX_W] <= char_index;
            end
            count_q <= count_q + 4'd1;
            if (count_q == LAST_SLOT) begin
              state_q <= ST_OUTPUT;
              error_q <= 1'b0;
            end
          end else if (expire) begin
            state_q <= ST_OUTPUT;
            error_q <= 1'b1;
          end
        end
        ST_OUTPUT: begin
          if (char_evt) overrun_q <= 1'b1;
          if (plate.plate_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy              = (state_q == ST_COLLECT);
  assign all_done          = (state_q == ST_OUTPUT);
  assign overrun           = overrun_q;
  assign plate.plate_valid = (state_q == ST_OUTPUT);
  assign plate.plate_data  = data_q;
  assign plate.plate_count = count_q;
  assign plate.plate_error = error_q;

endmodule
